// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types and constants for the multiport register file
package regfile_pkg;

  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_RUN   = 1'b1
  } rf_state_e;

  localparam int RF_DATA_W = 32;
  localparam int RF_ADDR_W = 5;
  localparam int RF_NUM_RD = 2;

  // Fixed registers watched by the syscall/IO logic
  localparam int TAP_SYSCALL = 2;
  localparam int TAP_STDOUT  = 4;

endpackage

// File: rtl/regfile_clear_fsm.sv
// rtl/regfile_clear_fsm.sv - post-reset sequencer that zeroes every array entry
module regfile_clear_fsm
  import regfile_pkg::*;
#(
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  output logic              clr_we_o,
  output logic [ADDR_W-1:0] clr_idx_o,
  output logic              ready_o
);

  localparam logic [ADDR_W-1:0] LAST_IDX = '1;

  rf_state_e         state_q, state_d;
  logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;
  logic              ready_q, ready_d;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= RF_CLEAR;
      clr_idx_q <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      ready_q   <= ready_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    ready_d   = ready_q;
    clr_we_o  = 1'b0;
    case (state_q)
      RF_CLEAR: begin
        clr_we_o  = 1'b1;
        clr_idx_d = clr_idx_q + 1'b1;
        // ready rises on the same edge that clears the last entry
        if (clr_idx_q == LAST_IDX) begin
          state_d = RF_RUN;
          ready_d = 1'b1;
        end
      end
      RF_RUN: begin
        state_d = RF_RUN;
      end
      default: begin
        state_d = RF_CLEAR;
      end
    endcase
  end

  assign clr_idx_o = clr_idx_q;
  assign ready_o   = ready_q;

endmodule

// File: rtl/regfile_multiport.sv
// rtl/regfile_multiport.sv - NUM_RD registered read ports, one write port, bypass and taps
module regfile_multiport
  import regfile_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int NUM_RD   = RF_NUM_RD,
  parameter bit ZERO_REG = 1'b1,
  parameter int TAP0_IDX = TAP_SYSCALL,
  parameter int TAP1_IDX = TAP_STDOUT
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic [NUM_RD-1:0]        rd_en_i,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
  output logic [NUM_RD*DATA_W-1:0] rd_data_o,
  input  logic                     wr_en_i,
  input  logic [ADDR_W-1:0]        wr_addr_i,
  input  logic [DATA_W-1:0]        wr_data_i,
  output logic                     ready_o,
  output logic [DATA_W-1:0]        tap0_o,
  output logic [DATA_W-1:0]        tap1_o
);

  localparam int                DEPTH  = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] TAP0_A = ADDR_W'(TAP0_IDX);
  localparam logic [ADDR_W-1:0] TAP1_A = ADDR_W'(TAP1_IDX);

  logic [DATA_W-1:0] mem [DEPTH];
  logic              ready;
  logic              clr_we;
  logic [ADDR_W-1:0] clr_idx;
  logic              wr_ok;

  regfile_clear_fsm #(
    .ADDR_W (ADDR_W)
  ) u_clear_fsm (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .clr_we_o  (clr_we),
    .clr_idx_o (clr_idx),
    .ready_o   (ready)
  );

  assign wr_ok = ready && wr_en_i && !(ZERO_REG && (wr_addr_i == '0));

  // No reset on the array: the clear sequencer initialises it after every reset
  always_ff @(posedge clk_i) begin
    if (clr_we) begin
      mem[clr_idx] <= '0;
    end else if (wr_ok) begin
      mem[wr_addr_i] <= wr_data_i;
    end
  end

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] rd_q, rd_d;

    assign addr = rd_addr_i[g*ADDR_W +: ADDR_W];

    // Zero register beats bypass, bypass beats the stored value
    always_comb begin
      rd_d = rd_q;
      if (!ready) begin
        rd_d = '0;
      end else if (rd_en_i[g]) begin
        if (ZERO_REG && (addr == '0)) begin
          rd_d = '0;
        end else if (wr_en_i && (wr_addr_i == addr)) begin
          rd_d = wr_data_i;
        end else begin
          rd_d = mem[addr];
        end
      end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        rd_q <= '0;
      end else begin
        rd_q <= rd_d;
      end
    end

    assign rd_data_o[g*DATA_W +: DATA_W] = rd_q;
  end

  assign ready_o = ready;
  assign tap0_o  = ready ? mem[TAP0_A] : '0;
  assign tap1_o  = ready ? mem[TAP1_A] : '0;

endmodule

// File: tb/tb_regfile_multiport.sv
// tb/tb_regfile_multiport.sv - scoreboard bench for regfile_multiport (ZERO_REG 1 and 0)
module tb_regfile_multiport;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  rd_en;
  logic [9:0]  rd_addr;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;

  logic [63:0] rd_data_a, rd_data_b;
  logic        ready_a, ready_b;
  logic [31:0] tap0_a, tap1_a, tap0_b, tap1_b;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  typedef struct {
    string       name;
    int          kind;
    int          port;
    int          dut;
    logic [31:0] exp;
    int          due;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  regfile_multiport #(.ZERO_REG(1'b1)) dut_a (
    .clk_i(clk), .rst_n_i(rst_n), .rd_en_i(rd_en), .rd_addr_i(rd_addr),
    .rd_data_o(rd_data_a), .wr_en_i(wr_en), .wr_addr_i(wr_addr),
    .wr_data_i(wr_data), .ready_o(ready_a), .tap0_o(tap0_a), .tap1_o(tap1_a)
  );

  regfile_multiport #(.ZERO_REG(1'b0)) dut_b (
    .clk_i(clk), .rst_n_i(rst_n), .rd_en_i(rd_en), .rd_addr_i(rd_addr),
    .rd_data_o(rd_data_b), .wr_en_i(wr_en), .wr_addr_i(wr_addr),
    .wr_data_i(wr_data), .ready_o(ready_b), .tap0_o(tap0_b), .tap1_o(tap1_b)
  );

  function automatic logic [31:0] actual(int kind, int port, int dut);
    logic [63:0] rd;
    rd = (dut == 0) ? rd_data_a : rd_data_b;
    case (kind)
      0:       return rd[port*32 +: 32];
      1:       return {31'd0, (dut == 0) ? ready_a : ready_b};
      2:       return (dut == 0) ? tap0_a : tap0_b;
      default: return (dut == 0) ? tap1_a : tap1_b;
    endcase
  endfunction

  task automatic compare(string name, int dut, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp)
      $display("FAIL %s dut%0d: got 0x%08h expected 0x%08h (cycle %0d)", name, dut, act, exp, cyc);
    else
      n_pass++;
  endtask

  // kind: 0 = rd_data port, 1 = ready, 2 = tap0, 3 = tap1; due is next edge
  task automatic push(string name, int kind, int port, logic [31:0] ea, logic [31:0] eb);
    exp_t e;
    e.name = name; e.kind = kind; e.port = port; e.due = cyc + 1;
    e.dut = 0; e.exp = ea; sb.push_back(e);
    e.dut = 1; e.exp = eb; sb.push_back(e);
  endtask

  task automatic check_now(string name, int kind, int port, logic [31:0] exp);
    compare(name, 0, actual(kind, port, 0), exp);
    compare(name, 1, actual(kind, port, 1), exp);
  endtask

  task automatic drive(logic we, logic [4:0] wa, logic [31:0] wd,
                       logic [1:0] re, logic [4:0] a0, logic [4:0] a1);
    wr_en = we; wr_addr = wa; wr_data = wd;
    rd_en = re; rd_addr = {a1, a0};
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    #1;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      compare(e.name, e.dut, actual(e.kind, e.port, e.dut), e.exp);
    end
  end

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 5'd0, 32'd0, 2'b11, 5'd1, 5'd2);
    repeat (3) @(negedge clk);
    check_now("reset_ready", 1, 0, 32'd0);
    check_now("reset_rd0", 0, 0, 32'd0);
    check_now("reset_tap0", 2, 0, 32'd0);
    check_now("reset_tap1", 3, 0, 32'd0);

    rst_n = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      if (k == 32) drive(1'b1, 5'd3, 32'h0000_0055, 2'b11, 5'd3, 5'd3);
      push($sformatf("clear_ready_e%0d", k), 1, 0, {31'd0, k == 32}, {31'd0, k == 32});
      if (k == 16) begin
        push("clear_rd0", 0, 0, 32'd0, 32'd0);
        push("clear_tap0", 2, 0, 32'd0, 32'd0);
      end
      @(negedge clk);
    end

    drive(1'b1, 5'd5, 32'hDEAD_BEEF, 2'b10, 5'd0, 5'd3);
    push("ignored_clear_wr_r3", 0, 1, 32'd0, 32'd0);
    @(negedge clk);
    drive(1'b0, 5'd0, 32'd0, 2'b01, 5'd5, 5'd0);
    push("read_r5", 0, 0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    push("port1_hold", 0, 1, 32'd0, 32'd0);
    @(negedge clk);
    drive(1'b1, 5'd7, 32'h0000_1234, 2'b11, 5'd8, 5'd7);
    push("bypass_r7", 0, 1, 32'h0000_1234, 32'h0000_1234);
    push("read_r8", 0, 0, 32'd0, 32'd0);
    @(negedge clk);
    drive(1'b0, 5'd0, 32'd0, 2'b00, 5'd5, 5'd5);
    push("hold_p0", 0, 0, 32'd0, 32'd0);
    push("hold_p1", 0, 1, 32'h0000_1234, 32'h0000_1234);
    @(negedge clk);
    drive(1'b1, 5'd0, 32'hFFFF_FFFF, 2'b01, 5'd0, 5'd0);
    push("r0_bypass", 0, 0, 32'd0, 32'hFFFF_FFFF);
    @(negedge clk);
    drive(1'b0, 5'd0, 32'd0, 2'b11, 5'd0, 5'd0);
    push("r0_read_p0", 0, 0, 32'd0, 32'hFFFF_FFFF);
    push("r0_read_p1", 0, 1, 32'd0, 32'hFFFF_FFFF);
    @(negedge clk);
    drive(1'b1, 5'd2, 32'h0000_000A, 2'b11, 5'd5, 5'd5);
    push("tap0_r2", 2, 0, 32'h0000_000A, 32'h0000_000A);
    push("same_addr_p0", 0, 0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    push("same_addr_p1", 0, 1, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    @(negedge clk);
    drive(1'b1, 5'd4, 32'h0000_1000, 2'b00, 5'd0, 5'd0);
    push("tap1_r4", 3, 0, 32'h0000_1000, 32'h0000_1000);
    push("tap0_kept", 2, 0, 32'h0000_000A, 32'h0000_000A);
    @(negedge clk);
    drive(1'b0, 5'd0, 32'd0, 2'b00, 5'd0, 5'd0);
    @(negedge clk);

    rst_n = 1'b0;
    #1;
    check_now("midrst_ready", 1, 0, 32'd0);
    check_now("midrst_rd0", 0, 0, 32'd0);
    check_now("midrst_rd1", 0, 1, 32'd0);
    check_now("midrst_tap0", 2, 0, 32'd0);
    check_now("midrst_tap1", 3, 0, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      if (k >= 31) push($sformatf("reclear_ready_e%0d", k), 1, 0, {31'd0, k == 32}, {31'd0, k == 32});
      @(negedge clk);
    end
    drive(1'b0, 5'd0, 32'd0, 2'b11, 5'd2, 5'd4);
    push("reclear_r2", 0, 0, 32'd0, 32'd0);
    push("reclear_r4", 0, 1, 32'd0, 32'd0);
    push("reclear_tap0", 2, 0, 32'd0, 32'd0);
    @(negedge clk);
    drive(1'b0, 5'd0, 32'd0, 2'b00, 5'd0, 5'd0);

    for (int t = 0; t < 10 && sb.size() > 0; t++) @(negedge clk);
    if (sb.size() > 0) begin
      n_chk++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/regfile_multiport.md
# regfile_multiport

Parametrised successor to the CPU's general-purpose register file. Provides `NUM_RD` independent registered read ports and one write port, with write-to-read bypass and an optional hard-wired zero register. A post-reset clear sequencer zeroes every entry, so the storage array needs no per-flop reset. Two tap outputs expose fixed registers (syscall code, stdout address) to the syscall/IO logic. Sits between decode (addresses) and the execute stage.

## Interface
- `DATA_W`, 32, register width in bits
- `ADDR_W`, 5, address width; depth `DEPTH = 2**ADDR_W`
- `NUM_RD`, 2, number of read ports (1..4)
- `ZERO_REG`, 1, 1 = entry 0 always reads 0 and ignores writes
- `TAP0_IDX`, 2, register index driven on `tap0`
- `TAP1_IDX`, 4, register index driven on `tap1`

- `clk`  in  1  single clock, all state on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `rd_en`  in  `NUM_RD`  per-port read enable
- `rd_addr`  in  `NUM_RD*ADDR_W`  port i at bits `[i*ADDR_W +: ADDR_W]`
- `rd_data`  out  `NUM_RD*DATA_W`  registered read data, port i at `[i*DATA_W +: DATA_W]`
- `wr_en`  in  1  write enable
- `wr_addr`  in  `ADDR_W`  write index
- `wr_data`  in  `DATA_W`  write value
- `ready`  out  1  high once clearing is complete; accesses are accepted only while high
- `tap0`, `tap1`  out  `DATA_W`  current contents of `TAP0_IDX` / `TAP1_IDX`

## Operation
- FSM states: CLEAR, RUN. `rst_n` low (at any time, including mid-RUN) forces CLEAR with `clr_idx=0`, `rd_data=0`, `ready=0`.
- CLEAR: each rising edge writes 0 to `array[clr_idx]` and increments `clr_idx`. On the edge that writes `DEPTH-1`, go to RUN and set `ready=1`. `wr_en` and `rd_en` are ignored; `rd_data` holds 0.
- RUN write: if `wr_en`, write `array[wr_addr] <= wr_data`. When `ZERO_REG=1` and `wr_addr==0`, the write is dropped.
- RUN read, per port i with `rd_en[i]=1`, priority order:
  1. `ZERO_REG` and `addr==0` -> 0.
  2. `wr_en` and `wr_addr==addr` -> `wr_data` (write-first bypass).
  3. Otherwise `array[addr]`.
- Port with `rd_en[i]=0` holds its previous `rd_data`.
- Any number of ports may read the same address in the same cycle; all receive the same value.
- Taps: `tap0 = ready ? array[TAP0_IDX] : 0`; `tap1` likewise. Combinational from the array, no bypass.

## Timing
- Reset values: `rd_data=0`, `ready=0`, `tap0=tap1=0`; FSM in CLEAR.
- Clearing takes exactly `DEPTH` rising edges after `rst_n` deasserts. With default parameters, `ready` rises after edge 32.
- Read latency is 1 cycle: address presented before edge N -> data valid after edge N, stable until the next enabled read.
- Write is visible to array reads issued on the next edge, and to taps after the write edge. A read issued on the same edge as the write gets the value via bypass.
- Reset mid-operation: outputs drop to 0 asynchronously; array contents are undefined until the new clear completes.

## Structure
- Package `regfile_pkg`: FSM state enum (`RF_CLEAR`, `RF_RUN`), default width constants, `TAP_SYSCALL=2`, `TAP_STDOUT=4`.
- Sub-module `regfile_clear_fsm`: owns state, `clr_idx`, and `ready`; outputs the clear write strobe and index to the top-level array mux.
- Read ports are built with a generate loop in the top level; no separate module.

## Test plan
- Reset, then idle: `ready` is 0 for 32 edges and 1 after edge 32. Every read returns 0, and taps are 0.
- With `ready=1`: write `0xDEADBEEF` to r5, then read r5 on port 0 the next cycle -> `rd_data[0]=0xDEADBEEF` one edge later.
- Same-edge write r7=`0x1234` while port 1 reads r7 -> port 1 returns `0x1234` (bypass). Port 0 reading r8 in the same cycle -> 0.
- Write `0xFFFFFFFF` to r0 with `ZERO_REG=1` -> reads of r0 return 0. Rerun with `ZERO_REG=0` -> read returns `0xFFFFFFFF`.
- Write r2=`0xA`, r4=`0x1000` -> `tap0=0xA` and `tap1=0x1000` after the respective write edges. Pulse `rst_n` low mid-stream -> taps, `rd_data`, and `ready` drop to 0 immediately; `ready` returns after 32 edges and r2 then reads 0.
